// File: rtl/prince_cms_pkg.sv
// Shared types and constants for the masked PRINCE S-box scheduler.
package prince_cms_pkg;

  // One 64-bit PRINCE state is sixteen 4-bit nibbles.
  localparam int NNIB  = 16;
  localparam int NIB_W = 4;

  typedef logic [3:0] nib_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fsm_t;

  // Unmasked PRINCE S-box; nibble i holds S(i).
  // Reference values only. The masked core derives its own algebraic form.
  localparam logic [63:0] PRINCE_SBOX = 64'h4D5E_0876_19CA_23FB;

  function automatic logic [3:0] sbox_nib(input logic [3:0] x);
    return PRINCE_SBOX[4*x +: 4];
  endfunction

  // Apply the S-box to all sixteen nibbles of an unshared state.
  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < NNIB; i++) begin
      y[NIB_W*i +: NIB_W] = sbox_nib(x[NIB_W*i +: NIB_W]);
    end
    return y;
  endfunction

endpackage

// File: rtl/prince_sbox_cms.sv
// Two-share masked PRINCE S-box.
// Each output bit is written in algebraic normal form. Every monomial is
// expanded over the share domains into cross-terms. One cross-term index s
// (bit b set = use share 1 of input bit b, clear = use share 0) collects
// every product that has exactly that share choice. So no single term ever
// sees both shares of one input bit.
// The terms are refreshed with fresh randomness and then registered. After
// that they are compressed into the two output shares and registered again.
// Extra stages beyond two are plain delay.
module prince_sbox_cms #(
  parameter int NSHARES = 2,
  parameter int LATENCY = 2,
  parameter int RAND_W  = 4
) (
  input  logic                 clk,
  input  logic [NSHARES*4-1:0] x_sh_i,
  input  logic [RAND_W-1:0]    rnd_i,
  output logic [NSHARES*4-1:0] y_sh_o
);

  // ANF coefficients of the PRINCE S-box: bit 16*o+m set means that
  // monomial m (the product of input bits set in m) appears in output bit o.
  localparam logic [63:0] ANF = 64'h39C5_4F0A_44E1_13D9;

  logic [3:0]          x0;
  logic [3:0]          x1;
  logic [63:0]         term_d;
  logic [63:0]         term_q;
  logic [NSHARES*4-1:0] comp;
  logic [NSHARES*4-1:0] dly_q [LATENCY-1];

  assign x0 = x_sh_i[3:0];
  assign x1 = x_sh_i[7:4];

  // Build the share-domain cross-terms and refresh them with randomness.
  // The same random bit enters one share-0 term and one share-1 term, so it
  // cancels only in the recombined value.
  always_comb begin
    logic prod;
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves it unassigned and no latch is inferred.
    term_d = '0;
    prod   = 1'b0;
    for (int o = 0; o < 4; o++) begin
      for (int s = 0; s < 16; s++) begin
        for (int m = 0; m < 16; m++) begin
          if (ANF[16*o + m] && ((m & s) == s)) begin
            prod = 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (m[b]) prod = prod & (s[b] ? x1[b] : x0[b]);
            end
            term_d[16*o + s] = term_d[16*o + s] ^ prod;
          end
        end
      end
      term_d[16*o]      = term_d[16*o]      ^ rnd_i[o % RAND_W];
      term_d[16*o + 15] = term_d[16*o + 15] ^ rnd_i[o % RAND_W];
    end
  end

  // Compress registered terms: s[3]==0 terms form share 0, the rest share 1.
  always_comb begin
    comp = '0;
    for (int o = 0; o < 4; o++) begin
      for (int s = 0; s < 16; s++) begin
        if (s < 8) comp[o]     = comp[o]     ^ term_q[16*o + s];
        else       comp[4 + o] = comp[4 + o] ^ term_q[16*o + s];
      end
    end
  end

  // Term register, output share register and any extra delay stages.
  // NOTE: this datapath has no reset. Stale contents are harmless because
  // the scheduler's tag pipe decides which outputs are used.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every stage samples the value from
    // before the edge. That is what gives a true shift behaviour.
    term_q   <= term_d;
    dly_q[0] <= comp;
    for (int i = 1; i < LATENCY - 1; i++) begin
      dly_q[i] <= dly_q[i-1];
    end
  end

  assign y_sh_o = dly_q[LATENCY-2];

endmodule

// File: rtl/prince_sbox_sched.sv
// Serial scheduler around one shared masked PRINCE S-box core.
// It takes a shared 64-bit state and issues one nibble per cycle for which
// randomness is available. A tag pipe tracks which core outputs are real.
// Each real output is written back, share-wise and in issue order, into the
// shared result state. Shares are only ever selected and routed, never
// combined.
module prince_sbox_sched
  import prince_cms_pkg::*;
#(
  parameter int NSHARES = 2,
  parameter int LATENCY = 2,
  parameter int RAND_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [NSHARES*64-1:0] state_in_sh,
  input  logic [RAND_W-1:0]     rnd_in,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  output logic [NSHARES*64-1:0] state_out_sh,
  output logic                  busy,
  output logic                  done
);

  localparam int       SH_W     = NNIB * NIB_W;
  localparam nib_idx_t LAST_NIB = nib_idx_t'(NNIB - 1);

  fsm_t                     state_q;
  fsm_t                     state_d;
  nib_idx_t                 issue_cnt_q;
  nib_idx_t                 issue_cnt_d;
  nib_idx_t                 ret_cnt_q;
  nib_idx_t                 ret_cnt_d;
  logic [NSHARES*SH_W-1:0]  in_reg_q;
  logic [NSHARES*SH_W-1:0]  out_q;
  logic [LATENCY-1:0]       tag_q;
  logic                     load_in;
  logic                     issue_fire;
  logic                     wb_fire;
  logic [NSHARES*NIB_W-1:0] core_x;
  logic [NSHARES*NIB_W-1:0] core_y;
  logic [RAND_W-1:0]        core_rnd;

  // The oldest tag marks a core output that belongs to an issued nibble.
  assign wb_fire      = tag_q[LATENCY-1];
  assign state_out_sh = out_q;

  // Next state, counter updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    start_ready = 1'b0;
    rnd_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    load_in     = 1'b0;
    issue_fire  = 1'b0;

    if (wb_fire) ret_cnt_d = ret_cnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          load_in     = 1'b1;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        rnd_ready = 1'b1;
        busy      = 1'b1;
        if (rnd_valid) begin
          issue_fire  = 1'b1;
          issue_cnt_d = issue_cnt_q + 4'd1;
          if (issue_cnt_q == LAST_NIB) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (wb_fire && (ret_cnt_q == LAST_NIB)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // While reset is held, no handshake output or issue may show through.
    if (rst) begin
      start_ready = 1'b0;
      rnd_ready   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      issue_fire  = 1'b0;
    end
  end

  // Core input mux: share k of the issued nibble comes only from share k.
  // Bubble cycles drive all-zero data and randomness.
  always_comb begin
    core_x   = '0;
    core_rnd = '0;
    if (issue_fire) begin
      for (int k = 0; k < NSHARES; k++) begin
        core_x[k*NIB_W +: NIB_W] = in_reg_q[k*SH_W + NIB_W*int'(issue_cnt_q) +: NIB_W];
      end
      core_rnd = rnd_in;
    end
  end

  // Control state, counters, tag pipe and share-wise result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      tag_q       <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      tag_q       <= {tag_q[LATENCY-2:0], issue_fire};
      if (wb_fire) begin
        for (int k = 0; k < NSHARES; k++) begin
          out_q[k*SH_W + NIB_W*int'(ret_cnt_q) +: NIB_W] <= core_y[k*NIB_W +: NIB_W];
        end
      end
    end
  end

  // Snapshot of the accepted input state, held for the whole run.
  always_ff @(posedge clk) begin
    if (load_in) in_reg_q <= state_in_sh;
  end

  prince_sbox_cms #(
    .NSHARES (NSHARES),
    .LATENCY (LATENCY),
    .RAND_W  (RAND_W)
  ) u_core (
    .clk    (clk),
    .x_sh_i (core_x),
    .rnd_i  (core_rnd),
    .y_sh_o (core_y)
  );

endmodule

// File: tb/tb_prince_sbox_sched.sv
// Self-checking bench for prince_sbox_sched: table-driven runs plus
// hand-written sequences for held start, mid-run reset and random stalls.
module tb_prince_sbox_sched;
  import prince_cms_pkg::*;

  localparam int LAT     = 2;
  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [127:0] state_in_sh;
  logic [3:0]   rnd_in;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [127:0] state_out_sh;
  logic         busy;
  logic         done;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] prev_y  = '0;

  always #5 clk = ~clk;

  prince_sbox_sched #(.NSHARES(2), .LATENCY(LAT), .RAND_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .state_in_sh  (state_in_sh),
    .rnd_in       (rnd_in),
    .rnd_valid    (rnd_valid),
    .rnd_ready    (rnd_ready),
    .state_out_sh (state_out_sh),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [63:0] s0;
    logic [63:0] s1;
    int          mode;
    logic [63:0] y;
    int          done_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // rnd_valid pattern for cycle cyc of a run (cycle 0 = start accepted).
  function automatic logic pat(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return cyc[0];
      2:       return (cyc % 3) == 1;
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic [63:0] out_xor();
    return state_out_sh[63:0] ^ state_out_sh[127:64];
  endfunction

  // One run, started in the current cycle (tb is just after a rising edge,
  // DUT idle). Returns just after the rising edge that follows done.
  // exp_done < 0 means: expect done LAT+1 cycles after the last issue.
  task automatic do_run(input logic [63:0] s0, input logic [63:0] s1, input int mode,
                        input logic hold_start, input logic [63:0] exp_y,
                        input int exp_done, input string tag);
    int   cyc;
    int   issues;
    int   last_issue;
    logic seen;
    logic rr_viol;
    logic sr_viol;
    cyc        = 0;
    issues     = 0;
    last_issue = -1;
    seen       = 1'b0;
    rr_viol    = 1'b0;
    sr_viol    = 1'b0;
    start_valid = 1'b1;
    state_in_sh = {s1, s0};
    rnd_valid   = pat(mode, 0);
    rnd_in      = 4'($urandom);
    while (!seen && cyc < TIMEOUT) begin
      @(negedge clk);
      if (cyc == 0) begin
        check({tag, " start_ready@0"}, 64'(start_ready), 64'd1);
        check({tag, " out held from previous run"}, out_xor(), prev_y);
      end
      if (cyc >= 1 && start_ready) sr_viol = 1'b1;
      if (rnd_ready && (!busy || issues >= 16)) rr_viol = 1'b1;
      if (rnd_valid && rnd_ready) begin
        issues++;
        last_issue = cyc;
      end
      if (done) begin
        seen = 1'b1;
        if (exp_done >= 0) check({tag, " done cycle"}, 64'(cyc), 64'(exp_done));
        else               check({tag, " done cycle"}, 64'(cyc), 64'(last_issue + LAT + 1));
        check({tag, " result"}, out_xor(), exp_y);
        check({tag, " issue count"}, 64'(issues), 64'd16);
        check({tag, " start_ready low in run"}, 64'(sr_viol), 64'd0);
        check({tag, " rnd_ready only in ISSUE"}, 64'(rr_viol), 64'd0);
        prev_y = exp_y;
      end
      @(posedge clk);
      #1;
      cyc++;
      start_valid = hold_start;
      rnd_valid   = pat(mode, cyc);
      rnd_in      = 4'($urandom);
    end
    if (!seen) check({tag, " done before timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] x;
    logic [63:0] r;
    logic        flag;

    vecs[0] = '{64'h0123456789ABCDEF, 64'h0, 0, 64'hBF32AC916780E5D4, 19};
    vecs[1] = '{64'h0123456789ABCDEF, 64'h0, 1, 64'hBF32AC916780E5D4, 34};
    vecs[2] = '{64'h5A5A5A5A5A5A5A5A, 64'h5A5A5A5A5A5A5A5A, 0, 64'hBBBBBBBBBBBBBBBB, 19};
    vecs[3] = '{64'hEDCBA9876543210F, 64'h123456789ABCDEF0, 0, 64'h4444444444444444, 19};
    vecs[4] = '{64'h0123BA9889AB3210, 64'hFFFF0000FFFF0000, 1, 64'h4D5E087619CA23FB, 34};
    vecs[5] = '{64'h0E2C4A6886A4C2E0, 64'h0F0F0F0F0F0F0F0F, 2, 64'hBF32AC916780E5D4, 49};

    // Reset state.
    rst         = 1'b1;
    start_valid = 1'b0;
    rnd_valid   = 1'b0;
    rnd_in      = '0;
    state_in_sh = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset start_ready", 64'(start_ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset rnd_ready", 64'(rnd_ready), 64'd0);
    check("reset state_out_sh lo", state_out_sh[63:0], 64'd0);
    check("reset state_out_sh hi", state_out_sh[127:64], 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle start_ready", 64'(start_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors: fixed, masked, bubbles every other / third cycle.
    for (int i = 0; i < 6; i++) begin
      do_run(vecs[i].s0, vecs[i].s1, vecs[i].mode, 1'b0, vecs[i].y,
             vecs[i].done_cyc, $sformatf("vec%0d", i));
    end

    // start_valid held high: accepts only in cycles 0 and 20.
    do_run(64'h0123456789ABCDEF, 64'h0, 0, 1'b1, 64'hBF32AC916780E5D4, 19, "hold run0");
    do_run(64'hFEDCBA9876543210, 64'h0, 0, 1'b1, 64'h4D5E087619CA23FB, 19, "hold run1");
    start_valid = 1'b0;

    // Reset asserted in cycle 8 of a run.
    start_valid = 1'b1;
    state_in_sh = {64'h0, 64'h0123456789ABCDEF};
    rnd_valid   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      start_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst rnd_ready during rst", 64'(rnd_ready), 64'd0);
    check("midrst start_ready during rst", 64'(start_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst start_ready", 64'(start_ready), 64'd1);
    check("midrst done", 64'(done), 64'd0);
    check("midrst state_out_sh lo", state_out_sh[63:0], 64'd0);
    check("midrst state_out_sh hi", state_out_sh[127:64], 64'd0);
    flag = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (done || busy) flag = 1'b1;
    end
    check("midrst no done or busy afterwards", 64'(flag), 64'd0);
    @(posedge clk);
    #1;
    prev_y = '0;
    do_run(64'h0E2C4A6886A4C2E0, 64'h0F0F0F0F0F0F0F0F, 0, 1'b0,
           64'hBF32AC916780E5D4, 19, "after midrst");

    // Random masked states: share0 = X^R, share1 = R.
    for (int i = 0; i < 100; i++) begin
      x = {$urandom, $urandom};
      r = {$urandom, $urandom};
      do_run(x ^ r, r, 0, 1'b0, sbox_layer(x), 19, $sformatf("rand%0d", i));
    end

    // Random rnd_valid stalls with back-to-back starts.
    for (int i = 0; i < 8; i++) begin
      x = {$urandom, $urandom};
      r = {$urandom, $urandom};
      do_run(x ^ r, r, 3, 1'b1, sbox_layer(x), -1, $sformatf("stall%0d", i));
    end
    start_valid = 1'b0;
    rnd_valid   = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
